// File: rtl/mem_port_initiator.sv
// Requester-side controller for one synchronous-read memory port: issues client requests,
// captures read data into a credit-protected response FIFO. Optional: MEM_PORT_INITIATOR_WRITE_ACK_EN.
module mem_port_initiator #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 64,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_we,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_PORT_INITIATOR_WRITE_ACK_EN
  output logic              rsp_is_wack,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
  // valid never depends on ready, and req_ready never depends on req_valid/req_we.

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              rd_pending;
  logic              accept;
  logic              push;
  logic              pop;
  logic              pend_set;
  logic [CNT_W:0]    credit_use;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] data_q [RSP_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop        = rsp_valid & rsp_ready;
  assign push       = rd_pending;
  // Credits cover both stored entries and the response still in flight from the memory.
  assign credit_use = {1'b0, count} + {{CNT_W{1'b0}}, rd_pending} - {{CNT_W{1'b0}}, pop};
  assign req_ready  = ~reset & (credit_use < (CNT_W + 1)'(RSP_DEPTH));
  assign accept     = req_valid & req_ready;

  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;
  assign mem_we    = accept & req_we;

  assign rsp_valid = (count != '0);
  assign rsp_rdata = rsp_valid ? data_q[rd_ptr] : '0;
  assign busy      = rd_pending | rsp_valid;

`ifdef MEM_PORT_INITIATOR_WRITE_ACK_EN
  logic pend_wack;
  logic wack_q [RSP_DEPTH];

  assign pend_set    = accept;
  assign push_data   = pend_wack ? '0 : mem_rdata;
  assign rsp_is_wack = rsp_valid & wack_q[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pend_wack <= 1'b0;
    else       pend_wack <= accept & req_we;
  end

  always_ff @(posedge clock) begin
    if (push) wack_q[wr_ptr] <= pend_wack;
  end
`else
  assign pend_set  = accept & ~req_we;
  assign push_data = mem_rdata;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pending <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      rd_pending <= pend_set;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; rsp_rdata is masked to zero while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) data_q[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Directed bench for mem_port_initiator with a behavioural 32 x 64 synchronous-read memory.
// Build with MEM_PORT_INITIATOR_WRITE_ACK_EN to also check write acknowledgements.
module tb_mem_port_initiator;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [63:0] req_wdata;
  logic        req_we;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic [4:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_we;
  logic [63:0] mem_rdata;
  logic        busy;
`ifdef MEM_PORT_INITIATOR_WRITE_ACK_EN
  logic        rsp_is_wack;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mem [32];

  mem_port_initiator #(.ADDR_W(5), .DATA_W(64), .RSP_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
`ifdef MEM_PORT_INITIATOR_WRITE_ACK_EN
    .rsp_is_wack(rsp_is_wack),
`endif
    .busy(busy)
  );

  // Clock and memory model
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd0;
    req_wdata = 64'h0; rsp_ready = 1'b0;
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 64'h0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    next_cycle;
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_req_ready: got %b want 1", req_ready); end
  endtask

  // Write a then read it on the next cycle; response appears two cycles after the read issue.
  task automatic test_write_read(input logic [4:0] a, input logic [63:0] d);
    next_cycle;
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clock);
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== a) begin n_err++; $display("FAIL wr_mem_addr: got %0d want %0d", mem_addr, a); end
    n_cmp++; if (mem_wdata !== d) begin n_err++; $display("FAIL wr_mem_wdata: got %h want %h", mem_wdata, d); end
    next_cycle;
    req_we = 1'b0; req_wdata = 64'h0;
    @(negedge clock);
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rd_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rd_req_ready: got %b want 1", req_ready); end
    next_cycle;
    req_valid = 1'b0;
    @(negedge clock);
`ifdef MEM_PORT_INITIATOR_WRITE_ACK_EN
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL wack_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_is_wack !== 1'b1) begin n_err++; $display("FAIL wack_flag: got %b want 1", rsp_is_wack); end
    n_cmp++; if (rsp_rdata !== 64'h0) begin n_err++; $display("FAIL wack_data: got %h want 0", rsp_rdata); end
`else
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL no_wr_rsp: got %b want 0", rsp_valid); end
`endif
    next_cycle;
    @(negedge clock);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== d) begin n_err++; $display("FAIL rd_rsp_data: got %h want %h", rsp_rdata, d); end
`ifdef MEM_PORT_INITIATOR_WRITE_ACK_EN
    n_cmp++; if (rsp_is_wack !== 1'b0) begin n_err++; $display("FAIL rd_wack_flag: got %b want 0", rsp_is_wack); end
`endif
    next_cycle;
    @(negedge clock);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_rd_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 32; i++) begin
      next_cycle;
      rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b1;
      req_addr = 5'(i); req_wdata = 64'(i) * 64'h0101;
      @(negedge clock);
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want 1", i, req_ready); end
    end
    next_cycle; req_valid = 1'b0; req_we = 1'b0;
    next_cycle;
    for (int k = 0; k < 34; k++) begin
      next_cycle;
      if (k < 32) begin req_valid = 1'b1; req_addr = 5'(k); end
      else req_valid = 1'b0;
      @(negedge clock);
      if (k < 32) begin
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b want 1", k, req_ready); end
        exp_q.push_back(64'(k) * 64'h0101);
      end
      if (k >= 2) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", k, rsp_valid); end
        n_cmp++; if (rsp_rdata !== e) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", k, rsp_rdata, e); end
      end
    end
    next_cycle;
    @(negedge clock);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", rsp_valid); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure;
    next_cycle;
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd1;
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_acc1: got %b want 1", req_ready); end
    next_cycle; req_addr = 5'd2;
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_acc2: got %b want 1", req_ready); end
    next_cycle; req_addr = 5'd3;
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall1: got %b want 0", req_ready); end
    n_cmp++; if (rsp_rdata !== 64'h0101) begin n_err++; $display("FAIL bp_head1: got %h want 0101", rsp_rdata); end
    next_cycle;
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall2: got %b want 0", req_ready); end
    next_cycle; rsp_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_pop_accept: got %b want 1", req_ready); end
    n_cmp++; if (rsp_rdata !== 64'h0101) begin n_err++; $display("FAIL bp_data1: got %h want 0101", rsp_rdata); end
    next_cycle; req_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (rsp_rdata !== 64'h0202) begin n_err++; $display("FAIL bp_data2: got %h want 0202", rsp_rdata); end
    next_cycle;
    @(negedge clock);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid3: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 64'h0303) begin n_err++; $display("FAIL bp_data3: got %h want 0303", rsp_rdata); end
    next_cycle;
    @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    next_cycle;
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7;
    next_cycle;
    req_we = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL mid_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
    @(posedge clock);
    #3 reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale[%0d]: got %b want 0", i, rsp_valid); end
      n_cmp++; if (rsp_rdata !== 64'h0) begin n_err++; $display("FAIL mid_rdata[%0d]: got %h want 0", i, rsp_rdata); end
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready[%0d]: got %b want 1", i, req_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read(5'd3, 64'hDEADBEEF_00000001);
    test_stream();
    test_backpressure();
    test_write_read(5'd5, 64'h0000_0000_0000_00A5);
    test_write_read(5'd9, 64'h0000_0000_0000_1234);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
